shared_port_arbiter: RTL
========================

SHARED_PORT_ARBITER -- requirements
Module: shared_port_arbiter

Interface
REQ-001 Parameter RV_BIT_NUM, default 32, data width of each requester beat and of the output.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  4  req[i]=1: requester i presents a valid beat on its d slice.
REQ-005 d  input  4*RV_BIT_NUM  packed beats; requester i at [i*RV_BIT_NUM+RV_BIT_NUM-1 : i*RV_BIT_NUM].
REQ-006 lock  input  4  lock[i]=1: requester i keeps ownership after its current beat (present only with SHARED_ARB_LOCK_EN).
REQ-007 gnt  output  4  one-hot or zero, combinational; gnt[i]=1: beat of requester i accepted this cycle.
REQ-008 q  output  RV_BIT_NUM  registered output beat.
REQ-009 q_valid  output  1  q holds an undelivered beat.
REQ-010 q_ready  input  1  consumer accepts q this cycle when q_valid=1.
REQ-011 q_src  output  2  index of the requester that produced q.

Function
REQ-012 One-entry output register; accept condition acc = !q_valid || q_ready.
REQ-013 States: IDLE (q_valid=0), DATA (q_valid=1), LOCKED (DATA or IDLE with an owner held; macro only).
REQ-014 Round-robin pointer ptr (2 bits): winner = first i with req[i]=1 scanning ptr, ptr+1, ... mod 4.
REQ-015 When acc=1 and any req: gnt[winner]=1 same cycle; next edge q<=d slice of winner, q_src<=winner, q_valid<=1, ptr<=(winner+1) mod 4 (3 wraps to 0).
REQ-016 When acc=1 and req=0: gnt=0; next edge q_valid<=0; q and q_src hold.
REQ-017 When q_valid=1 and q_ready=0 (stall): gnt=0; q, q_src, q_valid, ptr hold regardless of req.
REQ-018 Simultaneous drain and fill (q_valid=1, q_ready=1, req!=0): new beat loads same edge; sustained throughput one beat per cycle, no bubble.
REQ-019 Latency: gnt cycle N -> beat visible on q/q_valid at cycle N+1.
REQ-020 Fairness: with all four req held high and q_ready=1, grant order is 0,1,2,3,0,... from reset.
REQ-021 Requester deasserting req in a cycle where it is not granted loses nothing; arbiter never grants an unasserted req.
REQ-022 gnt is never nonzero when acc=0 or rst_n=0.

Reset
REQ-023 On rst_n=0 at a clock edge: q=0, q_valid=0, q_src=0, ptr=0, state=IDLE, lock owner cleared.
REQ-024 Reset mid-operation discards any pending q beat and any lock ownership; no gnt issued while rst_n=0.
REQ-025 First arbitration occurs in the first cycle with rst_n=1.

Configuration
REQ-026 Macro SHARED_ARB_LOCK_EN: when defined, lock port exists; granting requester i with lock[i]=1 enters LOCKED with owner i.
REQ-027 In LOCKED only the owner may be granted; other req ignored; ptr frozen; owner without req yields gnt=0 and holds ownership.
REQ-028 LOCKED exits when owner is granted with lock[owner]=0; ptr<=(owner+1) mod 4 on that grant.
REQ-029 Without SHARED_ARB_LOCK_EN: no lock port, no LOCKED state, pure round-robin per REQ-014..REQ-020.

Verification
REQ-030 Reset then req=4'b1111, q_ready=1, d slices 0xA0..0xA3 -> gnt 0001,0010,0100,1000,0001; q 0xA0,0xA1,0xA2,0xA3 one cycle later, q_src 0..3.
REQ-031 req=4'b0100, q_ready=0 for 3 cycles -> one gnt=0100, q_valid=1 holds q=d2 and q_src=2 for 3 cycles, gnt=0 during stall.
REQ-032 ptr=3 after grant to 2, req=4'b1001 -> gnt=1000 then 0001 (wrap-around order verified).
REQ-033 Beat in q (q_valid=1), assert rst_n=0 one cycle -> q_valid=0, q=0, q_src=0, next grant starts at requester 0.
REQ-034 Macro defined: req=4'b0011, lock[1]=1 for 2 grants then 0 -> grants 1,1,1 to requester 1 while req[0] waits, then requester 0.
REQ-035 req drops to 0 with q_ready=1 -> q_valid falls next edge, gnt=0, q retains last value.

Source files
------------

// File: rtl/shared_port_arbiter.sv
// Four-requester round-robin arbiter feeding a one-entry output register.
// Optional ownership locking is enabled with `define SHARED_ARB_LOCK_EN.
module shared_port_arbiter #(
  parameter int RV_BIT_NUM = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              req,
  input  logic [4*RV_BIT_NUM-1:0] d,
`ifdef SHARED_ARB_LOCK_EN
  input  logic [3:0]              lock,
`endif
  output logic [3:0]              gnt,
  output logic [RV_BIT_NUM-1:0]   q,
  output logic                    q_valid,
  input  logic                    q_ready,
  output logic [1:0]              q_src
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1
`ifdef SHARED_ARB_LOCK_EN
    , LOCKED = 2'd2
`endif
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [RV_BIT_NUM-1:0] beat [4];
  logic [RV_BIT_NUM-1:0] q_r;
  logic [1:0]            src_r;
  logic                  vld_q;
  logic [1:0]            ptr_q;

  logic                  acc;
  logic [1:0]            win;
  logic                  win_any;
  logic [1:0]            idx;
  logic [1:0]            sel;
  logic                  sel_any;
  logic                  fire;
  logic                  adv;

`ifdef SHARED_ARB_LOCK_EN
  logic [1:0]            own_q;
  logic                  locked;
  assign locked = (state_q == LOCKED);
`endif

  for (genvar i = 0; i < 4; i++) begin : g_beat
    assign beat[i] = d[i*RV_BIT_NUM +: RV_BIT_NUM];
  end

  assign acc  = !vld_q || q_ready;
  assign fire = rst_n && acc && sel_any;

  // Descending scan so the closest requester after ptr wins last.
  always_comb begin
    win     = ptr_q;
    win_any = 1'b0;
    idx     = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) begin
        win     = idx;
        win_any = 1'b1;
      end
    end
  end

  always_comb begin
    sel     = win;
    sel_any = win_any;
    adv     = 1'b1;
`ifdef SHARED_ARB_LOCK_EN
    if (locked) begin
      sel     = own_q;
      sel_any = req[own_q];
      adv     = !lock[own_q];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DATA: begin
        if (fire) begin
          state_d = DATA;
        end else if (acc) begin
          state_d = IDLE;
        end
`ifdef SHARED_ARB_LOCK_EN
        if (fire && lock[sel]) begin
          state_d = LOCKED;
        end
`endif
      end
`ifdef SHARED_ARB_LOCK_EN
      LOCKED: begin
        if (fire && !lock[own_q]) begin
          state_d = DATA;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt = 4'b0000;
    if (fire) begin
      gnt = 4'b0001 << sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r   <= '0;
      src_r <= 2'd0;
      vld_q <= 1'b0;
      ptr_q <= 2'd0;
    end else if (fire) begin
      q_r   <= beat[sel];
      src_r <= sel;
      vld_q <= 1'b1;
      if (adv) begin
        ptr_q <= sel + 2'd1;
      end
    end else if (acc) begin
      vld_q <= 1'b0;
    end
  end

`ifdef SHARED_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      own_q <= 2'd0;
    end else if (fire && !locked && lock[sel]) begin
      own_q <= sel;
    end
  end
`endif

  assign q       = q_r;
  assign q_src   = src_r;
  assign q_valid = vld_q;

endmodule
